bcd_scan_ctrl: RTL and testbench
================================

Name: bcd_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one bcd_to_decimal decoder across NDIG digit positions.
- Holds an NDIG-digit packed BCD value and presents one nibble at a time on bcd_out, which drives the shared decoder's BCD input.
- Selects the matching digit position with one-hot digit_sel and inserts a blanking gap between digits against ghosting.
- New values load through a frame-synchronous shadow register, so a frame never shows a mix of old and new digits.

Parameters:
NDIG, 4, number of digit positions (min 1)
DWELL, 8, clock cycles each digit is displayed (min 1)
GAP, 2, blank cycles after each digit (0 = no gap)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  one-cycle strobe; capture value
value  input  4*NDIG  packed BCD; nibble 0 = value[3:0] = least significant digit
clr_err  input  1  clears sticky err
bcd_out  output  4  nibble to shared decoder; 4'hF = blank
digit_sel  output  NDIG  one-hot active digit; all zero when blank or idle
frame_tick  output  1  one-cycle pulse at each frame boundary
pending  output  1  shadow holds a value not yet displayed
err  output  1  sticky; a loaded nibble was greater than 9

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- All outputs are registered.
- Reset values:
  - state IDLE
  - bcd_out = 4'hF, digit_sel = 0
  - frame_tick = 0, pending = 0, err = 0
  - active and shadow registers = 0
  - digit index = 0
- Reset asserted mid-operation forces the reset values immediately; no frame completion.
- FSM states: IDLE, SCAN, GAP.
- IDLE:
  - Outputs stay blank.
  - On load, value goes straight into active.
  - Next cycle: state SCAN, index 0, digit_sel[0] = 1, bcd_out = value[3:0]. Latency is one cycle.
  - No frame_tick on this entry.
- SCAN:
  - digit_sel = one-hot(index); bcd_out = active nibble[index].
  - Lasts exactly DWELL cycles, then goes to GAP, or straight to the next digit if GAP = 0.
- GAP:
  - digit_sel = 0, bcd_out = 4'hF for exactly GAP cycles.
  - Then index increments and the FSM returns to SCAN.
- Wrap and frame boundary:
  - Index NDIG-1 wraps to 0. One frame = NDIG*(DWELL+GAP) cycles.
  - frame_tick = 1 in the first SCAN cycle of digit 0 of every frame after the first.
  - In that same cycle, if pending = 1, active takes shadow and pending clears. The first digit of the frame already shows the new value.
- load while in SCAN or GAP:
  - shadow takes value; pending = 1 from the next cycle.
  - Repeated loads before the boundary overwrite shadow; the last one wins.
- load in the cycle that enters a new frame:
  - The incoming value goes directly into active, not the older shadow.
  - pending = 0.
- Invalid nibble (greater than 9):
  - The nibble is stored as-is and displayed as 4'hF (blank).
  - err = 1 the cycle after the load.
  - err stays set until clr_err is asserted or reset occurs.
  - If clr_err and a new error occur in the same cycle, set wins.
- The controller never returns to IDLE except through reset.

Optional Feature:
- Macro: BCD_SCAN_BLANK_LZ_EN.
- Defined: leading-zero blanking. Nibbles above the most significant non-zero nibble that equal 0 are output as 4'hF. Nibble 0 is never blanked, so value 0 shows a single "0". Invalid nibbles count as non-zero.
- Undefined: all zeros are displayed as 0.

Test Plan:
- Test parameters: NDIG = 4, DWELL = 4, GAP = 1.
- Reset, then load 16'h1234 in IDLE -> next cycle digit_sel = 0001, bcd_out = 4 for 4 cycles; then 1 cycle with digit_sel = 0000, bcd_out = F; then 0010/3, 0100/2, 1000/1; frame_tick pulses at cycle 20 after the SCAN entry, with digit_sel = 0001 again.
- Mid-frame load 16'h5678 -> pending = 1; the rest of the frame still shows 1234; at frame_tick, pending = 0 and the digits show 8, 7, 6, 5.
- Two mid-frame loads, 16'h1111 then 16'h2222 -> the next frame shows only 2, 2, 2, 2; no 1111 frame appears.
- Load 16'h12A4 -> err = 1 one cycle later; digit 1 shows F; the other digits show 4, 2, 1. Pulse clr_err -> err = 0. clr_err in the same cycle as a new erroneous load -> err stays 1.
- Drop rst_n during SCAN of digit 2 -> digit_sel = 0 and bcd_out = F without waiting for a clock edge; after release, outputs stay blank with no frame_tick until the next load.
- With BCD_SCAN_BLANK_LZ_EN defined: load 16'h0045 -> digits 5, 4, F, F; load 16'h0000 -> digits 0, F, F, F. With it undefined: 16'h0045 -> 5, 4, 0, 0.

Source files
------------

// File: rtl/bcd_scan_ctrl.sv
// bcd_scan_ctrl: time-multiplexed scan controller sharing one BCD-to-decimal
// decoder across NDIG digit positions, with blanking gaps between digits and
// a frame-synchronous shadow register for new values.
//
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   load         one-cycle strobe, capture value
//   value        packed BCD, nibble 0 = value[3:0] = least significant digit
//   clr_err      clears the sticky err flag
//   bcd_out      nibble to the shared decoder, 4'hF = blank
//   digit_sel    one-hot active digit, zero when blank or idle
//   frame_tick   one-cycle pulse at each frame boundary (not on first entry)
//   pending      shadow holds a value not yet displayed
//   err          sticky, a loaded nibble was greater than 9
//
// Optional build macro BCD_SCAN_BLANK_LZ_EN enables leading-zero blanking.

module bcd_scan_ctrl #(
    parameter int unsigned NDIG  = 4,
    parameter int unsigned DWELL = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic              clr_err,
    output logic [3:0]        bcd_out,
    output logic [NDIG-1:0]   digit_sel,
    output logic              frame_tick,
    output logic              pending,
    output logic              err
);

    localparam int unsigned VW = 4 * NDIG;
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned CW = $clog2(DWELL + GAP + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          r_state, w_nxt_state;
    logic [IW-1:0]   r_idx, w_nxt_idx;
    logic [CW-1:0]   r_cnt, w_nxt_cnt;
    logic [VW-1:0]   r_active, w_nxt_active;
    logic [VW-1:0]   r_shadow, w_nxt_shadow;
    logic            r_pending, w_nxt_pending;
    logic            r_err, w_nxt_err;
    logic            w_nxt_tick;
    logic            w_adv;
    logic [3:0]      r_bcd_out;
    logic [NDIG-1:0] r_digit_sel;
    logic            r_frame_tick;

    // One-hot decode of the digit index.
    function automatic logic [NDIG-1:0] f_onehot(input logic [IW-1:0] idx);
        logic [NDIG-1:0] s;
        s = '0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (idx == IW'(i)) s[i] = 1'b1;
        end
        return s;
    endfunction

    // Nibble shown for a digit; invalid nibbles (and optionally leading zeros) blank.
    function automatic logic [3:0] f_disp(input logic [VW-1:0] v, input logic [IW-1:0] idx);
        logic [3:0] n;
`ifdef BCD_SCAN_BLANK_LZ_EN
        logic       hi_zero;
        hi_zero = 1'b1;
`endif
        n = 4'hF;
        for (int i = int'(NDIG) - 1; i >= 0; i--) begin
`ifdef BCD_SCAN_BLANK_LZ_EN
            // hi_zero covers nibbles i..NDIG-1, so a zero digit with nothing above blanks.
            if (v[4*i +: 4] != 4'd0) hi_zero = 1'b0;
`endif
            if (idx == IW'(i)) begin
                n = v[4*i +: 4];
`ifdef BCD_SCAN_BLANK_LZ_EN
                if (i != 0 && hi_zero) n = 4'hF;
`endif
            end
        end
        if (n > 4'd9) n = 4'hF;
        return n;
    endfunction

    // True when any nibble of the loaded value is not a BCD digit.
    function automatic logic f_bad(input logic [VW-1:0] v);
        logic b;
        b = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (v[4*i +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_active     <= '0;
            r_shadow     <= '0;
            r_pending    <= 1'b0;
            r_err        <= 1'b0;
            r_frame_tick <= 1'b0;
            r_digit_sel  <= '0;
            r_bcd_out    <= 4'hF;
        end else begin
            r_state      <= w_nxt_state;
            r_idx        <= w_nxt_idx;
            r_cnt        <= w_nxt_cnt;
            r_active     <= w_nxt_active;
            r_shadow     <= w_nxt_shadow;
            r_pending    <= w_nxt_pending;
            r_err        <= w_nxt_err;
            r_frame_tick <= w_nxt_tick;
            // Outputs are registered from the next state so they line up with it.
            r_digit_sel  <= (w_nxt_state == S_SCAN) ? f_onehot(w_nxt_idx) : '0;
            r_bcd_out    <= (w_nxt_state == S_SCAN) ? f_disp(w_nxt_active, w_nxt_idx) : 4'hF;
        end
    end

    // Next-state, dwell/gap timing, shadow handling and sticky error.
    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_idx     = r_idx;
        w_nxt_cnt     = r_cnt;
        w_nxt_active  = r_active;
        w_nxt_shadow  = r_shadow;
        w_nxt_pending = r_pending;
        w_nxt_tick    = 1'b0;
        w_adv         = 1'b0;
        w_nxt_err     = (load && f_bad(value)) ? 1'b1 : (clr_err ? 1'b0 : r_err);

        case (r_state)
            S_IDLE: begin
                if (load) begin
                    w_nxt_state  = S_SCAN;
                    w_nxt_idx    = '0;
                    w_nxt_cnt    = '0;
                    w_nxt_active = value;
                end
            end
            S_SCAN: begin
                if (r_cnt == CW'(DWELL - 1)) begin
                    w_nxt_cnt = '0;
                    if (GAP == 0) w_adv = 1'b1;
                    else          w_nxt_state = S_GAP;
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == CW'(GAP - 1)) begin
                    w_nxt_cnt   = '0;
                    w_nxt_state = S_SCAN;
                    w_adv       = 1'b1;
                end else begin
                    w_nxt_cnt = r_cnt + CW'(1);
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase

        if (r_state != S_IDLE && load) begin
            w_nxt_shadow  = value;
            w_nxt_pending = 1'b1;
        end

        // Advancing past the last digit starts a new frame; a same-cycle load beats the shadow.
        if (w_adv) begin
            if (r_idx == IW'(NDIG - 1)) begin
                w_nxt_idx  = '0;
                w_nxt_tick = 1'b1;
                if (load) begin
                    w_nxt_active  = value;
                    w_nxt_pending = 1'b0;
                end else if (r_pending) begin
                    w_nxt_active  = r_shadow;
                    w_nxt_pending = 1'b0;
                end
            end else begin
                w_nxt_idx = r_idx + IW'(1);
            end
        end
    end

    assign bcd_out    = r_bcd_out;
    assign digit_sel  = r_digit_sel;
    assign frame_tick = r_frame_tick;
    assign pending    = r_pending;
    assign err        = r_err;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Scoreboard bench for bcd_scan_ctrl (NDIG=4, DWELL=4, GAP=1): the driver
// pushes per-cycle expectations from a frame-position reference model, a
// monitor pops and compares after every rising edge.

module tb_bcd_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DWELL = 4;
    localparam int GAP   = 1;
    localparam int P     = DWELL + GAP;
    localparam int FR    = NDIG * P;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        load    = 1'b0;
    logic        clr_err = 1'b0;
    logic [15:0] value   = '0;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        frame_tick;
    logic        pending;
    logic        err;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] bcd;
        logic       tick;
        logic       pend;
        logic       err;
    } exp_t;

    exp_t q[$];
    exp_t mon_e, mon_a;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   armed = 1'b0;
    bit   rst_hold = 1'b1;

    // Reference model state: cycles since scan entry, displayed and shadow values.
    bit          m_run = 1'b0;
    int          m_t = 0;
    logic [15:0] m_act = '0, m_sh = '0;
    logic        m_pend = 1'b0, m_err = 1'b0;

    bcd_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .clr_err    (clr_err),
        .bcd_out    (bcd_out),
        .digit_sel  (digit_sel),
        .frame_tick (frame_tick),
        .pending    (pending),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] m_disp(input logic [15:0] a, input int d);
        logic [15:0] sh;
        logic [3:0]  n;
        sh = a >> (4 * d);
        n  = sh[3:0];
        if (n > 4'd9) return 4'hF;
`ifdef BCD_SCAN_BLANK_LZ_EN
        if (d > 0 && sh == 16'h0) return 4'hF;
`endif
        return n;
    endfunction

    function automatic logic [15:0] rnd_val();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) begin
            v[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
        end
        if ($urandom_range(0, 2) == 0) v[15:8] = 8'h00;
        return v;
    endfunction

    // Drive one cycle of inputs and push the expected outputs after the next edge.
    task automatic cycle(input logic ld, input logic [15:0] val, input logic clr);
        exp_t e;
        int   pos;
        int   d;
        logic bad;
        @(negedge clk);
        rst_n   = !rst_hold;
        load    = ld;
        value   = val;
        clr_err = clr;
        e = '0;
        if (rst_hold) begin
            m_run = 1'b0; m_t = 0; m_act = '0; m_sh = '0; m_pend = 1'b0; m_err = 1'b0;
            e.bcd = 4'hF;
        end else begin
            bad = 1'b0;
            for (int k = 0; k < 4; k++) if (val[4*k +: 4] > 4'd9) bad = ld;
            if (!m_run) begin
                if (ld) begin
                    m_run = 1'b1; m_t = 0; m_act = val;
                end
            end else begin
                m_t++;
                if (m_t % FR == 0) begin
                    e.tick = 1'b1;
                    if (ld) begin
                        m_act = val; m_pend = 1'b0;
                    end else if (m_pend) begin
                        m_act = m_sh; m_pend = 1'b0;
                    end
                end else if (ld) begin
                    m_sh = val; m_pend = 1'b1;
                end
            end
            m_err = bad ? 1'b1 : (clr ? 1'b0 : m_err);
            pos = m_t % FR;
            d   = pos / P;
            if (m_run && (pos % P) < DWELL) begin
                e.sel = 4'(1 << d);
                e.bcd = m_disp(m_act, d);
            end else begin
                e.sel = 4'h0;
                e.bcd = 4'hF;
            end
            e.pend = m_pend;
            e.err  = m_err;
        end
        q.push_back(e);
        armed = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 1'b0);
    endtask

    // Assert reset between clock edges and check outputs blank immediately.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (digit_sel !== 4'h0 || bcd_out !== 4'hF || frame_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset got sel=%b bcd=%h tick=%b want sel=0000 bcd=f tick=0",
                     digit_sel, bcd_out, frame_tick);
        end
        rst_hold = 1'b1;
        idle(3);
        rst_hold = 1'b0;
    endtask

    // Monitor: one expectation per rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (armed) begin
                n_vec++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL scoreboard_underflow t=%0t got no expectation want one", $time);
                end else begin
                    mon_e = q.pop_front();
                    mon_a = {digit_sel, bcd_out, frame_tick, pending, err};
                    if (mon_a !== mon_e) begin
                        n_bad++;
                        $display("FAIL scb t=%0t got sel=%b bcd=%h tick=%b pend=%b err=%b want sel=%b bcd=%h tick=%b pend=%b err=%b",
                                 $time, mon_a.sel, mon_a.bcd, mon_a.tick, mon_a.pend, mon_a.err,
                                 mon_e.sel, mon_e.bcd, mon_e.tick, mon_e.pend, mon_e.err);
                    end
                end
            end
        end
    end

    initial begin
        rst_hold = 1'b1;
        idle(3);
        rst_hold = 1'b0;
        idle(2);

        cycle(1'b1, 16'h1234, 1'b0);
        idle(24);
        cycle(1'b1, 16'h5678, 1'b0);
        idle(30);
        cycle(1'b1, 16'h1111, 1'b0);
        idle(3);
        cycle(1'b1, 16'h2222, 1'b0);
        idle(30);

        cycle(1'b1, 16'h12A4, 1'b0);
        idle(25);
        cycle(1'b0, 16'h0, 1'b1);
        idle(3);
        cycle(1'b1, 16'h12B4, 1'b1);
        idle(5);
        cycle(1'b0, 16'h0, 1'b1);

        cycle(1'b1, 16'h0045, 1'b0);
        idle(25);
        cycle(1'b1, 16'h0000, 1'b0);
        idle(25);

        // Older shadow pending, then a load exactly on the frame boundary.
        cycle(1'b1, 16'h3333, 1'b0);
        for (int i = 0; i < FR && ((m_t + 1) % FR) != 0; i++) idle(1);
        cycle(1'b1, 16'h9876, 1'b0);
        idle(25);

        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 11) == 0), rnd_val(), ($urandom_range(0, 19) == 0));
        end

        // Reset during SCAN of digit 2.
        async_reset();
        idle(2);
        cycle(1'b1, 16'h4321, 1'b0);
        idle(11);
        async_reset();
        idle(30);
        cycle(1'b1, 16'h0987, 1'b0);
        idle(25);

        @(posedge clk);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got %0d left want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
